// File: rtl/lzc_norm_pkg.sv
//------------------------------------------------------------------------------
// Module  : lzc_norm_pkg
// Brief   : Shared constants and stage-1 register layout for the LZC normalizer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lzc_norm_pkg;

    localparam int          DATA_W_C   = 32;
    localparam int          LZC_W_C    = 6;
    localparam logic [5:0]  LZC_ZERO_C = 6'd32;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  rem;
        logic        sticky;
        logic        lz32;
        logic        range_err;
    } s1_t;

endpackage

`default_nettype wire

// File: rtl/lzc_normalizer_pipe_if.sv
//------------------------------------------------------------------------------
// Module  : lzc_normalizer_pipe_if
// Brief   : Upstream and downstream valid/ready bus of the LZC normalizer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lzc_normalizer_pipe_if #(
    parameter int EXP_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [5:0]        in_lzc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_lzc, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_lzc, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_err
    );
endinterface

`default_nettype wire

// File: rtl/lzc_norm_stage.sv
//------------------------------------------------------------------------------
// Module  : lzc_norm_stage
// Brief   : Valid/data pipeline register; holds its contents while not advancing.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lzc_norm_stage #(
    parameter int WIDTH = 1
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_adv,
    input  wire              i_valid,
    input  wire [WIDTH-1:0]  i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            // Bubbles leave the payload untouched so a drained stage keeps its last word.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/lzc_normalizer_pipe.sv
//------------------------------------------------------------------------------
// Module  : lzc_normalizer_pipe
// Brief   : Two-stage normalizer: shifts a word left by its LZC, emits biased
//           exponent plus zero/consistency flags. Optional transfer statistics
//           are enabled with the LZC_NORM_STATS_EN macro.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lzc_normalizer_pipe
    import lzc_norm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int EXP_W    = 8,
    parameter int EXP_BIAS = 127
) (
    input  wire                  clk,
    input  wire                  rst_n,
    lzc_normalizer_pipe_if.slave bus
`ifdef LZC_NORM_STATS_EN
    ,
    output logic [15:0]          stat_words,
    output logic [15:0]          stat_zero,
    output logic [15:0]          stat_err
`endif
);

    localparam int S1_W = $bits(s1_t) + 3;
    localparam int S2_W = DATA_W + EXP_W + 2;

    logic            w_s1_valid;
    logic            w_s2_valid;
    logic            w_s1_adv;
    logic            w_s2_adv;
    s1_t             w_s1_in;
    s1_t             w_s1_q;
    logic [2:0]      w_s1_hi;
    logic [63:0]     w_coarse;
    logic [63:0]     w_fine;
    logic            w_sticky2;
    logic            w_err;
    logic            w_zero;
    logic [5:0]      w_lzc;
    logic [EXP_W-1:0] w_exp_raw;
    logic [DATA_W-1:0] w_mant;
    logic [EXP_W-1:0]  w_exp;
    logic [S2_W-1:0]   w_s2_q;

    assign w_s2_adv     = !w_s2_valid || bus.out_ready;
    assign w_s1_adv     = !w_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    // Coarse shift by multiples of 8; anything pushed above bit 31 feeds sticky.
    assign w_coarse = {32'd0, bus.in_data} << {bus.in_lzc[5:3], 3'b000};

    always_comb begin
        w_s1_in           = '0;
        w_s1_in.data      = w_coarse[31:0];
        w_s1_in.rem       = bus.in_lzc[2:0];
        w_s1_in.sticky    = |w_coarse[63:32];
        w_s1_in.lz32      = (bus.in_lzc == LZC_ZERO_C);
        w_s1_in.range_err = (bus.in_lzc > LZC_ZERO_C);
    end

    lzc_norm_stage #(
        .WIDTH (S1_W)
    ) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (w_s1_adv),
        .i_valid (bus.in_valid),
        .i_data  ({w_s1_in, bus.in_lzc[5:3]}),
        .o_valid (w_s1_valid),
        .o_data  ({w_s1_q, w_s1_hi})
    );

    assign w_fine    = {32'd0, w_s1_q.data} << w_s1_q.rem;
    assign w_sticky2 = w_s1_q.sticky || (|w_fine[63:32]);
    assign w_lzc     = {w_s1_hi, w_s1_q.rem};
    assign w_exp_raw = EXP_W'(EXP_BIAS + 31) - EXP_W'(w_lzc);

    // A correct count leaves nothing shifted out and a 1 in bit 31.
    always_comb begin
        w_err  = 1'b0;
        w_zero = 1'b0;
        if (w_s1_q.range_err) begin
            w_err = 1'b1;
        end else if (w_s1_q.lz32) begin
            w_err  = w_sticky2;
            w_zero = !w_sticky2;
        end else begin
            w_err = w_sticky2 || !w_fine[31];
        end
    end

    always_comb begin
        w_mant = '0;
        w_exp  = '0;
        if (!w_err && !w_zero) begin
            w_mant = DATA_W'(w_fine[31:0]);
            w_exp  = w_exp_raw;
        end
    end

    lzc_norm_stage #(
        .WIDTH (S2_W)
    ) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (w_s2_adv),
        .i_valid (w_s1_valid),
        .i_data  ({w_mant, w_exp, w_zero, w_err}),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_q)
    );

    assign bus.out_valid = w_s2_valid;
    assign bus.out_mant  = 32'(w_s2_q[S2_W-1 -: DATA_W]);
    assign bus.out_exp   = w_s2_q[EXP_W+1:2];
    assign bus.out_zero  = w_s2_q[1];
    assign bus.out_err   = w_s2_q[0];

`ifdef LZC_NORM_STATS_EN
    logic        w_out_fire;
    logic [15:0] r_stat_words;
    logic [15:0] r_stat_zero;
    logic [15:0] r_stat_err;

    assign w_out_fire = w_s2_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_words <= '0;
            r_stat_zero  <= '0;
            r_stat_err   <= '0;
        end else if (w_out_fire) begin
            if (r_stat_words != 16'hFFFF) r_stat_words <= r_stat_words + 16'd1;
            if (bus.out_zero && (r_stat_zero != 16'hFFFF)) r_stat_zero <= r_stat_zero + 16'd1;
            if (bus.out_err && (r_stat_err != 16'hFFFF)) r_stat_err <= r_stat_err + 16'd1;
        end
    end

    assign stat_words = r_stat_words;
    assign stat_zero  = r_stat_zero;
    assign stat_err   = r_stat_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lzc_normalizer_pipe.sv
//------------------------------------------------------------------------------
// Module  : tb_lzc_normalizer_pipe
// Brief   : Scoreboard bench for lzc_normalizer_pipe with a behavioural model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lzc_normalizer_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lzc_normalizer_pipe_if #(.EXP_W(8)) bus ();

`ifdef LZC_NORM_STATS_EN
    logic [15:0] stat_words, stat_zero, stat_err;
`endif

    lzc_normalizer_pipe #(
        .DATA_W   (32),
        .EXP_W    (8),
        .EXP_BIAS (127)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef LZC_NORM_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_zero  (stat_zero),
        .stat_err   (stat_err)
`endif
    );

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   accepted = 0;
    int   delivered = 0;
    bit   chk_lat = 1'b0;
    bit   chk_inrdy = 1'b0;
    bit   held = 1'b0;
    logic [31:0] h_mant;
    logic [7:0]  h_exp;
    logic        h_zero, h_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int tb_clz(logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 31 - i;
        end
        return 32;
    endfunction

    // Reference: trust the supplied count only if it equals the true leading-zero count.
    function automatic exp_t model(logic [31:0] d, logic [5:0] l);
        exp_t r;
        r.mant = 32'd0; r.exp = 8'd0; r.zero = 1'b0; r.err = 1'b0; r.cyc = 0; r.lat = 1'b0;
        if (int'(l) > 32) begin
            r.err = 1'b1;
        end else if (int'(l) == 32) begin
            if (d == 32'd0) r.zero = 1'b1;
            else            r.err  = 1'b1;
        end else if (tb_clz(d) == int'(l)) begin
            r.mant = d << l;
            r.exp  = 8'((127 + 31 - int'(l)) % 256);
        end else begin
            r.err = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_t e;
            e = model(bus.in_data, bus.in_lzc);
            e.cyc = cyc;
            e.lat = chk_lat;
            q.push_back(e);
            accepted++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_mant", 64'(bus.out_mant), 64'(h_mant));
                chk("hold_exp", 64'(bus.out_exp), 64'(h_exp));
                chk("hold_flags", 64'({bus.out_zero, bus.out_err}), 64'({h_zero, h_err}));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_mant", 64'(bus.out_mant), 64'(e.mant));
                    chk("out_exp", 64'(bus.out_exp), 64'(e.exp));
                    chk("out_zero", 64'(bus.out_zero), 64'(e.zero));
                    chk("out_err", 64'(bus.out_err), 64'(e.err));
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                    delivered++;
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            h_mant = bus.out_mant;
            h_exp  = bus.out_exp;
            h_zero = bus.out_zero;
            h_err  = bus.out_err;
        end
    end

    task automatic send(logic [31:0] d, logic [5:0] l);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_lzc   = l;
        @(negedge clk);
        if (chk_inrdy) chk("in_ready_stream", 64'(bus.in_ready), 64'd1);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !bus.out_valid) break;
        end
        chk("drain_queue", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
    endtask

    function automatic logic [31:0] rand_consistent(int sh);
        logic [31:0] d;
        if (sh >= 32) return 32'd0;
        d = $urandom;
        d = (d >> sh) | (32'h80000000 >> sh);
        return d;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, sh;
        bit tog_run;
        bit sender_done;
        logic [31:0] d;
        logic [5:0]  l;

        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_lzc   = 6'd0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_mant", 64'(bus.out_mant), 64'd0);
        chk("rst_out_exp", 64'(bus.out_exp), 64'd0);
        chk("rst_out_flags", 64'({bus.out_zero, bus.out_err}), 64'd0);
`ifdef LZC_NORM_STATS_EN
        chk("rst_stats", 64'({stat_words, stat_zero, stat_err}), 64'd0);
`endif
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;

        send(32'h00010000, 6'd15);
        send(32'h00000000, 6'd32);
        send(32'h00010000, 6'd14);
        send(32'h00010000, 6'd16);
        send(32'h00010000, 6'd40);
        send(32'h00000005, 6'd32);
        send(32'h80000000, 6'd0);
        send(32'h00000001, 6'd31);
        send(32'h00000000, 6'd63);
        drain();

        chk_inrdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sh = $urandom_range(0, 32);
            send(rand_consistent(sh), 6'(sh));
        end
        chk_inrdy = 1'b0;
        drain();

        // Mixed consistent/inconsistent words under random back-pressure.
        chk_lat = 1'b0;
        tog_run = 1'b1;
        fork
            while (tog_run) begin
                @(posedge clk);
                #1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) l = 6'(tb_clz(d));
            else                           l = 6'($urandom_range(0, 63));
            send(d, l);
        end
        tog_run = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        bus.out_ready = 1'b0;
        a0 = accepted;
        d0 = delivered;
        sender_done = 1'b0;
        fork
            begin
                send(32'h12345678, 6'd3);
                send(32'h00F00000, 6'd8);
                send(32'h00000003, 6'd30);
                sender_done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        chk("stall_accepted", 64'(accepted - a0), 64'd2);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && !sender_done; t++) @(posedge clk);
        #1;
        drain();
        chk("stall_delivered", 64'(delivered - d0), 64'd3);

        send(32'h00000100, 6'd23);
        bus.out_ready = 1'b0;
        send(32'h00000200, 6'd22);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drop_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
`ifdef LZC_NORM_STATS_EN
        chk("stats_after_reset", 64'({stat_words, stat_zero, stat_err}), 64'd0);
`endif
        d0 = delivered;
        send(32'h00004000, 6'd17);
        drain();
        chk("post_reset_delivered", 64'(delivered - d0), 64'd1);

`ifdef LZC_NORM_STATS_EN
        send(32'h00004000, 6'd3);
        drain();
        chk("stats_words_2", 64'(stat_words), 64'd2);
        chk("stats_err_1", 64'(stat_err), 64'd1);
        for (int i = 0; i < 70000; i++) send(32'd0, 6'd32);
        drain();
        chk("stats_words_sat", 64'(stat_words), 64'hFFFF);
        chk("stats_zero_sat", 64'(stat_zero), 64'hFFFF);
        chk("stats_err_hold", 64'(stat_err), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lzc_normalizer_pipe.md
Name: lzc_normalizer_pipe

Overview:
- Sits directly downstream of the 32-bit count-leading-zeros (nlz) stage.
- Takes a data word plus its leading-zero count (0..32).
- Left-shifts the word so its MSB is 1 and emits a biased exponent, a zero flag and a consistency-error flag.
- Two-stage pipelined barrel shift with valid/ready handshake on both sides; feeds int-to-float packing and FHE-benchmark normalization paths.

Parameters:
- DATA_W, 32: operand width. Only 32 is supported; the LZC width is fixed at 6 bits.
- EXP_W, 8: output exponent width.
- EXP_BIAS, 127: constant added to the exponent. out_exp = EXP_BIAS + 31 - lzc, computed modulo 2^EXP_W.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  32  word to normalize.
- in_lzc  in  6  leading-zero count of in_data from the nlz stage; 32 means in_data == 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  32  normalized word: bit31 = 1 unless zero or error.
- out_exp  out  EXP_W  biased exponent; 0 when out_zero = 1.
- out_zero  out  1  input was zero (lzc == 32 and data == 0).
- out_err  out  1  in_lzc inconsistent with in_data.

Behaviour:
- Reset (async assert, sync release): s1_valid = s2_valid = 0, out_valid = 0, out_mant = 0, out_exp = 0, out_zero = 0, out_err = 0, stat counters = 0.
- Reset mid-operation drops all in-flight words; no partial output is emitted.
- Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (on input transfer):
  - Shift in_data left by {lzc[5], lzc[4], lzc[3]} × (32/16/8 as applicable).
  - Capture the residual shift lzc[2:0].
  - Set sticky = OR of all bits shifted out.
  - Set lz32 = (lzc == 32); set range error if lzc > 32.
- Stage 2: shift by lzc[2:0]; OR shifted-out bits into sticky; form flags and exponent.
- Result classification:
  - lzc == 32 and data == 0: out_zero = 1, out_mant = 0, out_exp = 0, out_err = 0.
  - lzc == 32 and data != 0: out_err = 1.
  - lzc > 32: out_err = 1.
  - lzc < 32 and (sticky or shifted bit31 == 0): out_err = 1.
  - When out_err = 1: out_mant = 0, out_exp = 0, out_zero = 0.
  - Otherwise: out_mant = in_data << lzc; out_exp = EXP_BIAS + 31 - lzc.
- Latency: exactly 2 cycles from input transfer to out_valid with no stall. Throughput 1 word/cycle.
- Stall rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no comb path from in_valid).
  - Stalled stages hold their data unchanged.
  - out_* must stay stable while out_valid & !out_ready.
- Simultaneous input and output transfer with both stages full: both stages advance and the pipeline stays full, no bubble.
- out_valid never drops without a transfer.

Optional Feature:
- Macro: LZC_NORM_STATS_EN.
- When defined, adds three outputs:
  - stat_words (16 bit): count of output transfers.
  - stat_zero (16 bit): count of output transfers with out_zero.
  - stat_err (16 bit): count of output transfers with out_err.
  - All counters saturate at 0xFFFF and reset to 0.
- When not defined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package lzc_norm_pkg: DATA_W_C = 32, LZC_W_C = 6, LZC_ZERO_C = 6'd32, and the stage-1 register struct typedef s1_t {data[31:0], rem[2:0], sticky, lz32, range_err}.
- One sub-module, lzc_norm_stage, holding the generic valid/data pipeline register with the hold-on-stall rule; instantiated twice.

Test Plan:
- in_data = 0x00010000, in_lzc = 15, out_ready = 1 → 2 cycles later out_mant = 0x80000000, out_exp = 143, out_zero = 0, out_err = 0.
- in_data = 0, in_lzc = 32 → out_zero = 1, out_mant = 0, out_exp = 0, out_err = 0.
- Error cases, each → out_err = 1, out_mant = 0:
  - in_data = 0x00010000, in_lzc = 14 (bit31 = 0 after shift).
  - in_lzc = 16 (sticky set).
  - in_lzc = 40.
  - in_data = 5, in_lzc = 32.
- Back-to-back stream of 100 random consistent (data, lzc) pairs with out_ready = 1 → one result per cycle, in order, matching the golden model; in_ready constantly 1.
- Hold out_ready = 0 for 5 cycles with 3 words offered → in_ready falls after 2 accepted; out_* stable; release delivers all 3 in order with no loss or duplication.
- Assert rst_n low while both stages are valid → out_valid = 0 immediately; after release, first new word appears after 2 cycles. With LZC_NORM_STATS_EN defined, counters read 0 after reset and saturate at 0xFFFF after 70000 zero words.
